// File: rtl/mux_pkg.sv
// Shared types for the registered 2:1 selector.
// Optional parity output is enabled by defining MUX_PARITY_EN.
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } mux_sel_e;

endpackage

// File: rtl/mux_if.sv
// Data/select bundle for the registered 2:1 selector.
// out_par exists only when MUX_PARITY_EN is defined.
interface mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] out;
`ifdef MUX_PARITY_EN
  logic             out_par;
`endif

`ifdef MUX_PARITY_EN
  modport master (
    output a, b, sel,
    input  out, out_par
  );
  modport slave (
    input  a, b, sel,
    output out, out_par
  );
`else
  modport master (
    output a, b, sel,
    input  out
  );
  modport slave (
    input  a, b, sel,
    output out
  );
`endif

endinterface

// File: rtl/mux_pipe_reg.sv
// Synchronous-reset D register, clears to zero.
// Holds the selected data and, when enabled, its parity.
module mux_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over d on the same edge.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/mux.sv
// Registered 2:1 selector: sel=0 forwards a, sel=1 forwards b.
// Define MUX_PARITY_EN to add a registered even-parity bit out_par.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  mux_if.slave bus
);

  mux_sel_e         sel_e;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] out_q;

  assign sel_e = mux_sel_e'(bus.sel);

  // Pick the operand; an unknown select yields X rather than a masked value.
  always_comb begin
    sel_d = 'x;
    unique case (sel_e)
      SEL_A:   sel_d = bus.a;
      SEL_B:   sel_d = bus.b;
      default: sel_d = 'x;
    endcase
  end

  mux_pipe_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .d   (sel_d),
    .q   (out_q)
  );

  assign bus.out = out_q;

`ifdef MUX_PARITY_EN
  logic [0:0] par_d;
  logic [0:0] par_q;

  // Parity of the value being captured, so it lines up with out.
  always_comb begin
    par_d = ^sel_d;
  end

  mux_pipe_reg #(
    .WIDTH (1)
  ) u_par_reg (
    .clk (clk),
    .rst (rst),
    .d   (par_d),
    .q   (par_q)
  );

  assign bus.out_par = par_q[0];
`endif

endmodule

// File: tb/tb_mux.sv
// Bench for mux at WIDTH=1 and WIDTH=8.
// Parity checks are active when MUX_PARITY_EN is defined.
module tb_mux;
  import mux_pkg::*;

  logic clk;
  logic rst;

  mux_if #(.WIDTH(1)) b1 ();
  mux_if #(.WIDTH(8)) b8 ();

  mux #(.WIDTH(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  mux #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic e;
  } vec_t;

  typedef struct {
    logic       e1;
    logic [7:0] e8;
    string      nm;
  } exp_t;

  vec_t tbl[8];
  exp_t sbq[$];
  int   checks;
  int   errors;

  task automatic chk(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic check_out(input exp_t x);
    chk({x.nm, "/w1"}, {7'b0, b1.out},
        {7'b0, x.e1});
    chk({x.nm, "/w8"}, b8.out, x.e8);
`ifdef MUX_PARITY_EN
    chk({x.nm, "/p1"}, {7'b0, b1.out_par},
        {7'b0, x.e1});
    chk({x.nm, "/p8"}, {7'b0, b8.out_par},
        {7'b0, ^x.e8});
`endif
  endtask

  // Drive one vector on the falling edge,
  // then compare just after the rising edge.
  task automatic step(
    input logic       r,
    input logic       a1,
    input logic       bb1,
    input logic       s1,
    input logic [7:0] a8,
    input logic [7:0] bb8,
    input logic       s8,
    input logic       e1,
    input logic [7:0] e8,
    input string      nm
  );
    exp_t x;
    @(negedge clk);
    rst    = r;
    b1.a   = a1;
    b1.b   = bb1;
    b1.sel = s1;
    b8.a   = a8;
    b8.b   = bb8;
    b8.sel = s8;
    sbq.push_back('{e1, e8, nm});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      x = sbq.pop_front();
      check_out(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    exp_t x;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    b1.a   = 1'b1;
    b1.b   = 1'b1;
    b1.sel = 1'b1;
    b8.a   = 8'hFF;
    b8.b   = 8'hFF;
    b8.sel = 1'b1;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held two edges with all inputs high.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1,
           8'hFF, 8'hFF, 1'b1,
           1'b0, 8'h00, "reset");

    // Truth table swept twice.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = tbl[i % 8];
      step(1'b0, v.a, v.b, v.sel,
           {8{v.a}}, {8{v.b}}, v.sel,
           v.e, {8{v.e}}, $sformatf("tt%0d", i));
    end

    // Latency: old value persists until the edge.
    step(1'b0, 1'b0, 1'b0, 1'b1,
         8'h00, 8'h00, 1'b1,
         1'b0, 8'h00, "lat_pre");
    @(negedge clk);
    b1.a   = 1'b1;
    b1.b   = 1'b0;
    b1.sel = 1'b0;
    b8.a   = 8'hFF;
    b8.b   = 8'h00;
    b8.sel = 1'b0;
    #1;
    chk("lat_hold", {7'b0, b1.out}, 8'h00);
    chk("lat_hold8", b8.out, 8'h00);
    sbq.push_back('{1'b1, 8'hFF, "lat_n1"});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check_out(x);
    step(1'b0, 1'b1, 1'b0, 1'b1,
         8'hFF, 8'h00, 1'b1,
         1'b0, 8'h00, "lat_sel");

    // Mid-run reset discards captured data.
    step(1'b0, 1'b1, 1'b0, 1'b0,
         8'hFF, 8'h00, 1'b0,
         1'b1, 8'hFF, "mid_pre");
    step(1'b1, 1'b1, 1'b0, 1'b0,
         8'hFF, 8'h00, 1'b0,
         1'b0, 8'h00, "mid_rst");
    step(1'b0, 1'b1, 1'b0, 1'b0,
         8'hFF, 8'h00, 1'b0,
         1'b1, 8'hFF, "mid_rel");

    // Wide patterns and parity.
    step(1'b0, 1'b1, 1'b0, 1'b0,
         8'hA5, 8'h3C, 1'b0,
         1'b1, 8'hA5, "w8_a");
    step(1'b0, 1'b1, 1'b0, 1'b1,
         8'hA5, 8'h3C, 1'b1,
         1'b0, 8'h3C, "w8_b");
    step(1'b0, 1'b0, 1'b1, 1'b1,
         8'hA5, 8'h01, 1'b1,
         1'b1, 8'h01, "w8_par");

    // sel toggles every cycle.
    for (int i = 0; i < 32; i++) begin
      s = i[0];
      step(1'b0, 1'b1, 1'b0, s,
           8'hFF, 8'h00, s,
           ~s, s ? 8'h00 : 8'hFF,
           $sformatf("tog%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
